// File: rtl/uart_cmd_regfile.sv
// Framed UART write-command decoder driving a flat register file; result lands on the edge that sees the CHK byte.
// No backpressure: bytes arrive on rx_busy falling edges; aborts a frame after TIMEOUT idle cycles.
module uart_cmd_regfile #(
  parameter  int NUM_REGS   = 13,
  parameter  int DATA_BYTES = 4,
  parameter  int CLEAR_CMD  = 15,
  parameter  int TIMEOUT    = 4095,
  localparam int REG_W      = 8 * DATA_BYTES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_busy,
  input  logic [7:0]                rx_data,
  output logic [NUM_REGS*REG_W-1:0] regs,
  output logic [NUM_REGS-1:0]       wr_strobe,
  output logic                      frame_ok,
  output logic                      frame_err,
  output logic [1:0]                err_code,
  output logic [7:0]                err_count
);

  localparam logic [7:0]  NUM_REGS_B = 8'(NUM_REGS);
  localparam logic [7:0]  CLEAR_B    = 8'(CLEAR_CMD);
  localparam logic [2:0]  LAST_IDX   = 3'(DATA_BYTES - 1);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

  state_t           state_q, state_d;
  logic             prev_busy;
  logic [7:0]       cmd_q;
  logic [7:0]       chk_q;
  logic [2:0]       idx_q;
  logic [15:0]      timer_q;
  logic [REG_W-1:0] buff_q;

  logic byte_evt, timeout_hit, resolve, chk_bad, cmd_bad;
  logic do_write, do_clear, do_reject;

  assign byte_evt    = prev_busy & ~rx_busy;
  assign timeout_hit = (state_q != IDLE) && !byte_evt && (timer_q == TIMER_LAST);
  assign chk_bad     = (rx_data != chk_q);
  assign cmd_bad     = (cmd_q >= NUM_REGS_B) && (cmd_q != CLEAR_B);

  always_comb begin
    state_d   = state_q;
    resolve   = 1'b0;
    case (state_q)
      IDLE:  if (byte_evt) state_d = DATA;
      DATA: begin
        if (byte_evt && idx_q == LAST_IDX) state_d = CHECK;
        else if (timeout_hit)              state_d = IDLE;
      end
      CHECK: begin
        if (byte_evt) begin
          state_d = IDLE;
          resolve = 1'b1;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Checksum failure outranks a bad command code.
  assign do_reject = resolve && (chk_bad || cmd_bad);
  assign do_clear  = resolve && !chk_bad && (cmd_q == CLEAR_B);
  assign do_write  = resolve && !chk_bad && !cmd_bad && (cmd_q != CLEAR_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prev_busy <= 1'b0;
      cmd_q     <= '0;
      chk_q     <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      buff_q    <= '0;
      regs      <= '0;
      wr_strobe <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      prev_busy <= rx_busy;
      wr_strobe <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (state_d == IDLE || byte_evt) timer_q <= '0;
      else                             timer_q <= timer_q + 16'd1;

      if (byte_evt) begin
        if (state_q == IDLE) begin
          cmd_q <= rx_data;
          chk_q <= rx_data;
          idx_q <= '0;
        end else if (state_q == DATA) begin
          buff_q <= (buff_q << 8) | REG_W'(rx_data);
          chk_q  <= chk_q ^ rx_data;
          idx_q  <= idx_q + 3'd1;
        end
      end

      if (do_write) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (cmd_q == 8'(k)) begin
            regs[k*REG_W +: REG_W] <= buff_q;
            wr_strobe[k]           <= 1'b1;
          end
        end
        frame_ok <= 1'b1;
        err_code <= 2'd0;
      end

      if (do_clear) begin
        regs      <= '0;
        wr_strobe <= '1;
        frame_ok  <= 1'b1;
        err_code  <= 2'd0;
      end

      if (do_reject || timeout_hit) begin
        frame_err <= 1'b1;
        err_code  <= timeout_hit ? 2'd3 : (chk_bad ? 2'd1 : 2'd2);
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_regfile.sv
// Randomized and directed checks of uart_cmd_regfile against a frame-level reference model.
module tb_uart_cmd_regfile;

  localparam int NR  = 13;
  localparam int RW  = 32;
  localparam int TMO = 4095;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, rst_s, rx_busy;
  logic [7:0]     rx_data;
  logic [NR*RW-1:0] regs;
  logic [NR-1:0]  wr_strobe;
  logic           frame_ok, frame_err;
  logic [1:0]     err_code;
  logic [7:0]     err_count;

  logic [31:0]    regs_s;
  logic [3:0]     strobe_s;
  logic           ok_s, err_s;
  logic [1:0]     code_s;
  logic [7:0]     cnt_s;

  uart_cmd_regfile dut (
    .clk(clk), .rst(rst), .rx_busy(rx_busy), .rx_data(rx_data),
    .regs(regs), .wr_strobe(wr_strobe), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .err_count(err_count)
  );

  uart_cmd_regfile #(.NUM_REGS(4), .DATA_BYTES(1), .CLEAR_CMD(15), .TIMEOUT(TMO)) dut_s (
    .clk(clk), .rst(rst_s), .rx_busy(rx_busy), .rx_data(rx_data),
    .regs(regs_s), .wr_strobe(strobe_s), .frame_ok(ok_s), .frame_err(err_s),
    .err_code(code_s), .err_count(cnt_s)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state and the pulses expected on the resolving cycle.
  logic [31:0]    m_regs [NR];
  int             m_code, m_cnt;
  logic [NR-1:0]  e_strobe;
  logic           e_ok, e_err;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [31:0] d);
    return cmd ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  function automatic logic [NR*RW-1:0] model_flat();
    logic [NR*RW-1:0] f;
    f = '0;
    for (int k = 0; k < NR; k++) f[k*RW +: RW] = m_regs[k];
    return f;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NR; k++) m_regs[k] = '0;
    m_code = 0;
    m_cnt  = 0;
  endfunction

  function automatic void model_reject(input int code);
    e_err  = 1'b1;
    m_code = code;
    if (m_cnt < 255) m_cnt = m_cnt + 1;
  endfunction

  function automatic void model_frame(input logic [7:0] cmd, input logic [31:0] d, input logic [7:0] chk);
    e_strobe = '0;
    e_ok     = 1'b0;
    e_err    = 1'b0;
    if (chk != frame_chk(cmd, d)) model_reject(1);
    else if (cmd >= NR && cmd != 15) model_reject(2);
    else if (cmd == 15) begin
      for (int k = 0; k < NR; k++) m_regs[k] = '0;
      e_strobe = '1;
      e_ok     = 1'b1;
      m_code   = 0;
    end else begin
      m_regs[cmd]   = d;
      e_strobe[cmd] = 1'b1;
      e_ok          = 1'b1;
      m_code        = 0;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_busy = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_busy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] d, input logic [7:0] chk);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
    send_byte(chk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_s = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst_s = 1'b0;
    model_reset();
    @(negedge clk);
    total++; if (regs !== '0) begin bad++; $display("FAIL reset_regs got=%h exp=0", regs); end
    total++; if (wr_strobe !== '0) begin bad++; $display("FAIL reset_strobe got=%h exp=0", wr_strobe); end
    total++; if ({frame_ok, frame_err} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b exp=00", {frame_ok, frame_err}); end
    total++; if (err_code !== 2'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", err_code); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_write();
    send_frame(8'h02, 32'h12345678, 8'h0A);
    model_frame(8'h02, 32'h12345678, 8'h0A);
    @(negedge clk);
    total++; if (regs[2*RW +: RW] !== 32'h12345678) begin bad++; $display("FAIL write_reg2 got=%h exp=12345678", regs[2*RW +: RW]); end
    total++; if (regs !== model_flat()) begin bad++; $display("FAIL write_others got=%h exp=%h", regs, model_flat()); end
    total++; if (wr_strobe !== 13'h0004) begin bad++; $display("FAIL write_strobe got=%h exp=0004", wr_strobe); end
    total++; if ({frame_ok, frame_err} !== 2'b10) begin bad++; $display("FAIL write_pulses got=%b exp=10", {frame_ok, frame_err}); end
    total++; if (err_code !== 2'd0) begin bad++; $display("FAIL write_code got=%0d exp=0", err_code); end
    @(negedge clk);
    total++; if ({wr_strobe, frame_ok} !== '0) begin bad++; $display("FAIL write_pulse_len got=%h exp=0", {wr_strobe, frame_ok}); end
  endtask

  task automatic test_checksum();
    send_frame(8'h02, 32'h12345678, 8'h0B);
    model_frame(8'h02, 32'h12345678, 8'h0B);
    @(negedge clk);
    total++; if (regs[2*RW +: RW] !== 32'h12345678) begin bad++; $display("FAIL chk_reg2 got=%h exp=12345678", regs[2*RW +: RW]); end
    total++; if ({wr_strobe, frame_ok, frame_err} !== 15'h0001) begin bad++; $display("FAIL chk_pulses got=%h exp=0001", {wr_strobe, frame_ok, frame_err}); end
    total++; if (err_code !== 2'd1) begin bad++; $display("FAIL chk_code got=%0d exp=1", err_code); end
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL chk_count got=%0d exp=1", err_count); end
  endtask

  task automatic test_bad_cmd_clear();
    send_frame(8'h0D, 32'h00000001, 8'h0C);
    model_frame(8'h0D, 32'h00000001, 8'h0C);
    @(negedge clk);
    total++; if ({wr_strobe, frame_ok, frame_err} !== 15'h0001) begin bad++; $display("FAIL badcmd_pulses got=%h exp=0001", {wr_strobe, frame_ok, frame_err}); end
    total++; if (err_code !== 2'd2) begin bad++; $display("FAIL badcmd_code got=%0d exp=2", err_code); end
    total++; if (regs !== model_flat()) begin bad++; $display("FAIL badcmd_regs got=%h exp=%h", regs, model_flat()); end
    send_frame(8'h0F, 32'h00000000, 8'h0F);
    model_frame(8'h0F, 32'h00000000, 8'h0F);
    @(negedge clk);
    total++; if (regs !== '0) begin bad++; $display("FAIL clear_regs got=%h exp=0", regs); end
    total++; if (wr_strobe !== 13'h1FFF) begin bad++; $display("FAIL clear_strobe got=%h exp=1fff", wr_strobe); end
    total++; if ({frame_ok, frame_err, err_code} !== 4'b1000) begin bad++; $display("FAIL clear_status got=%b exp=1000", {frame_ok, frame_err, err_code}); end
    total++; if (err_count !== 8'd2) begin bad++; $display("FAIL clear_count got=%0d exp=2", err_count); end
  endtask

  task automatic test_random();
    logic [7:0]  cmd, chk;
    logic [31:0] d;
    for (int n = 0; n < 40; n++) begin
      cmd = 8'($urandom_range(0, 16));
      d   = $urandom;
      chk = frame_chk(cmd, d);
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      send_frame(cmd, d, chk);
      model_frame(cmd, d, chk);
      @(negedge clk);
      total++; if (regs !== model_flat()) begin bad++; $display("FAIL rand_regs n=%0d got=%h exp=%h", n, regs, model_flat()); end
      total++; if ({wr_strobe, frame_ok, frame_err} !== {e_strobe, e_ok, e_err}) begin bad++; $display("FAIL rand_pulses n=%0d got=%h exp=%h", n, {wr_strobe, frame_ok, frame_err}, {e_strobe, e_ok, e_err}); end
      total++; if ({err_code, err_count} !== {2'(m_code), 8'(m_cnt)}) begin bad++; $display("FAIL rand_status n=%0d got=%0d/%0d exp=%0d/%0d", n, err_code, err_count, m_code, m_cnt); end
      // rx_busy stays low here: no further events and pulses must drop.
      repeat ($urandom_range(1, 4)) @(negedge clk);
      total++; if ({wr_strobe, frame_ok, frame_err, regs} !== {15'h0, model_flat()}) begin bad++; $display("FAIL rand_hold n=%0d strobe=%h ok=%b err=%b", n, wr_strobe, frame_ok, frame_err); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int n = 0; n < 12; n++) begin
      d = $urandom;
      send_frame(8'(n), d, frame_chk(8'(n), d));
      model_frame(8'(n), d, frame_chk(8'(n), d));
    end
    @(negedge clk);
    total++; if (regs !== model_flat()) begin bad++; $display("FAIL b2b_regs got=%h exp=%h", regs, model_flat()); end
    total++; if (err_count !== 8'(m_cnt)) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", err_count, m_cnt); end
  endtask

  task automatic test_timeout();
    logic seen;
    seen = 1'b0;
    send_byte(8'h05);
    send_byte(8'hAA);
    @(negedge clk);
    seen = frame_err;
    repeat (TMO - 1) begin
      @(negedge clk);
      seen = seen | frame_err;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL tmo_early got=1 exp=0"); end
    @(negedge clk);
    model_reject(3);
    total++; if ({frame_ok, frame_err} !== 2'b01) begin bad++; $display("FAIL tmo_pulse got=%b exp=01", {frame_ok, frame_err}); end
    total++; if ({err_code, err_count} !== {2'd3, 8'(m_cnt)}) begin bad++; $display("FAIL tmo_status got=%0d/%0d exp=3/%0d", err_code, err_count, m_cnt); end
    @(negedge clk);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL tmo_pulse_len got=%b exp=0", frame_err); end
    send_frame(8'h05, 32'h00000007, 8'h02);
    model_frame(8'h05, 32'h00000007, 8'h02);
    @(negedge clk);
    total++; if (regs[5*RW +: RW] !== 32'h7) begin bad++; $display("FAIL tmo_next_reg5 got=%h exp=7", regs[5*RW +: RW]); end
    total++; if ({wr_strobe, frame_ok, err_code} !== {13'h0020, 1'b1, 2'd0}) begin bad++; $display("FAIL tmo_next_status got=%h exp=%h", {wr_strobe, frame_ok, err_code}, {13'h0020, 1'b1, 2'd0}); end
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    total++; if ({regs, wr_strobe, frame_ok, frame_err, err_code, err_count} !== '0) begin bad++; $display("FAIL midrst_outputs cnt=%0d code=%0d regs=%h", err_count, err_code, regs); end
    send_frame(8'h07, 32'hDEADBEEF, 8'h25);
    model_frame(8'h07, 32'hDEADBEEF, 8'h25);
    @(negedge clk);
    total++; if (regs[7*RW +: RW] !== 32'hDEADBEEF) begin bad++; $display("FAIL midrst_reg7 got=%h exp=deadbeef", regs[7*RW +: RW]); end
    total++; if ({frame_ok, frame_err, err_count} !== {2'b10, 8'd0}) begin bad++; $display("FAIL midrst_status got=%h exp=200", {frame_ok, frame_err, err_count}); end
  endtask

  task automatic test_saturate();
    logic [31:0] d;
    for (int n = 0; n < 300; n++) begin
      d = $urandom;
      send_frame(8'h01, d, frame_chk(8'h01, d) ^ 8'h01);
      model_frame(8'h01, d, frame_chk(8'h01, d) ^ 8'h01);
    end
    @(negedge clk);
    total++; if (err_count !== 8'd255) begin bad++; $display("FAIL sat_count got=%0d exp=255", err_count); end
    total++; if (err_count !== 8'(m_cnt)) begin bad++; $display("FAIL sat_model got=%0d exp=%0d", err_count, m_cnt); end
    total++; if (regs !== model_flat()) begin bad++; $display("FAIL sat_regs got=%h exp=%h", regs, model_flat()); end
  endtask

  task automatic test_small();
    rst_s = 1'b1;
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    send_byte(8'h03);
    send_byte(8'h5A);
    send_byte(8'h59);
    @(negedge clk);
    total++; if (regs_s !== 32'h5A000000) begin bad++; $display("FAIL small_regs got=%h exp=5a000000", regs_s); end
    total++; if (strobe_s !== 4'b1000) begin bad++; $display("FAIL small_strobe got=%b exp=1000", strobe_s); end
    total++; if ({ok_s, err_s, code_s, cnt_s} !== {2'b10, 2'd0, 8'd0}) begin bad++; $display("FAIL small_status got=%h exp=800", {ok_s, err_s, code_s, cnt_s}); end
  endtask

  initial begin
    rst = 1'b1; rst_s = 1'b1; rx_busy = 1'b0; rx_data = '0;
    test_reset();
    test_write();
    test_checksum();
    test_bad_cmd_clear();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_midframe();
    test_saturate();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/uart_cmd_regfile.md
# uart_cmd_regfile

Parametrised UART command decoder and configuration register file that replaces the hard-coded command/byte-shift logic in the top level. It consumes bytes from the UART receiver (busy-falling-edge handshake), assembles framed write commands with an XOR checksum and an inter-byte timeout, and drives a flat bus of NUM_REGS configuration registers into the generator core. Per-register write strobes, a clear-all command and error reporting are features the current ad-hoc decoder lacks.

## Interface
- NUM_REGS, 13: number of registers; command codes 0..NUM_REGS-1 address them (range 1..255).
- DATA_BYTES, 4: payload bytes per frame; register width REG_W = 8*DATA_BYTES (range 1..4).
- CLEAR_CMD, 15: command code that zeroes every register; must be >= NUM_REGS.
- TIMEOUT, 4095: clock cycles allowed between bytes of a frame before abort (range 1..65535).

- clk  in  1  system clock (same domain as UART_RX).
- rst  in  1  synchronous, active-high reset.
- rx_busy  in  1  UART_RX busy; a byte is valid on its 1->0 transition.
- rx_data  in  8  UART_RX data byte; stable when rx_busy falls.
- regs  out  NUM_REGS*REG_W  register file, register k at bits [k*REG_W +: REG_W].
- wr_strobe  out  NUM_REGS  one-cycle pulse per register written (all bits on clear).
- frame_ok  out  1  one-cycle pulse on an accepted frame.
- frame_err  out  1  one-cycle pulse on a rejected/aborted frame.
- err_code  out  2  cause of last completed frame: 0 ok, 1 checksum, 2 bad command, 3 timeout.
- err_count  out  8  rejected frames since reset, saturating at 255.

## Operation
- Byte event: prev_busy registered each cycle (reset 0); event = prev_busy & ~rx_busy.
- Frame: CMD, then DATA_BYTES payload bytes MSB first, then CHK = XOR of CMD and all payload bytes. Total DATA_BYTES+2 bytes.
- State machine (events only advance it):
  - IDLE: event -> latch cmd, chk_acc = byte, idx = 0, -> DATA.
  - DATA: event -> shift byte into buff (buff = {buff, byte}), chk_acc ^= byte, idx++; after DATA_BYTES payload bytes -> CHECK.
  - CHECK: event -> compare byte to chk_acc, resolve, -> IDLE.
- Resolution in CHECK, priority order: checksum mismatch -> err 1; cmd >= NUM_REGS and != CLEAR_CMD -> err 2; else accept.
- Accept, cmd < NUM_REGS: regs[cmd] <= buff, wr_strobe[cmd] pulses, frame_ok pulses, err_code <= 0.
- Accept, cmd == CLEAR_CMD: all regs <= 0, wr_strobe all ones for one cycle, frame_ok pulses (payload ignored but checksummed).
- Reject: no register changes, frame_err pulses, err_code updated, err_count += 1 unless 255.
- Timeout: idle counter cleared on every event and held 0 in IDLE; in DATA/CHECK it increments; reaching TIMEOUT with no event that cycle -> IDLE, frame_err pulse, err_code 3, err_count += 1. Event and timeout in same cycle: event wins, counter clears.
- Next byte after any resolution/abort is treated as CMD.

## Timing
- Reset values: regs 0, wr_strobe 0, frame_ok 0, frame_err 0, err_code 0, err_count 0, state IDLE, prev_busy 0, idx 0, timer 0.
- Reset mid-frame discards partial frame with no error counted.
- Latency: the clock edge that registers rx_busy=0 (with prev_busy=1) for the CHK byte also updates regs and asserts strobes; visible the cycle after rx_busy is first sampled low. Strobes/pulses last exactly one cycle.
- rx_busy held low does not generate further events; back-to-back frames need no gap cycles.
- Timeout abort fires on the TIMEOUT-th cycle after the last event.

## Test plan
- Defaults; frame 02 12 34 56 78 0A -> regs[2]=0x12345678, wr_strobe=0x0004 one cycle, frame_ok pulse, err_code 0, other regs unchanged.
- Frame 02 12 34 56 78 0B -> regs[2] unchanged, frame_err pulse, err_code 1, err_count 1.
- Frame 0D 00 00 00 01 0C (cmd 13, NUM_REGS 13) -> no write, err_code 2; then 0F 00 00 00 00 0F -> all regs 0, wr_strobe=0x1FFF, frame_ok.
- Send 05 AA then stall TIMEOUT cycles -> frame_err on cycle TIMEOUT after AA event, err_code 3; following frame 05 00 00 00 07 02 accepted, regs[5]=7.
- Assert rst after third byte of a frame -> all outputs 0, next full valid frame accepted normally; drive 300 bad frames -> err_count stops at 255.
- DATA_BYTES=1, NUM_REGS=4: frame 03 5A 59 -> regs[3]=0x5A, wr_strobe=0b1000.
